// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - debounced set/clear command source for a level-sensitive SR latch (option: SR_DRV_SHADOW_EN)
module sr_latch_driver #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_set_n,
  input  logic key_clr_n,
  output logic s,
  output logic r,
  output logic c,
  output logic conflict,
  output logic q_exp
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Channel 0 is the set key, channel 1 the clear key.
  logic [1:0] keys_n;
  logic [1:0] press_evt;

  assign keys_n = {key_clr_n, key_set_n};

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_ch
      logic            sync_a;
      logic            sync_b;
      state_t          state;
      logic [CW-1:0]   cnt;
      logic            evt;

      // Two-flop synchronizer, inverted so a pressed key reads as 1.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_a <= 1'b0;
          sync_b <= 1'b0;
        end else begin
          sync_a <= ~keys_n[i];
          sync_b <= sync_a;
        end
      end

      // Debounce FSM; evt marks the cycle after the PRESS_WAIT->HELD transition.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= IDLE;
          cnt   <= CNT_ZERO;
          evt   <= 1'b0;
        end else begin
          evt <= 1'b0;
          case (state)
            IDLE: begin
              if (sync_b) begin
                state <= PRESS_WAIT;
                cnt   <= CNT_ONE;
              end else begin
                cnt <= CNT_ZERO;
              end
            end
            PRESS_WAIT: begin
              if (!sync_b) begin
                state <= IDLE;
                cnt   <= CNT_ZERO;
              end else if (cnt >= CNT_MAX - CNT_ONE) begin
                // Count reaches the threshold on this edge: level accepted.
                state <= HELD;
                cnt   <= CNT_MAX;
                evt   <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
            HELD: begin
              if (!sync_b) begin
                state <= RELEASE_WAIT;
                cnt   <= CNT_ONE;
              end
            end
            RELEASE_WAIT: begin
              if (sync_b) begin
                // Bounce during release: still held, no new pulse.
                state <= HELD;
                cnt   <= CNT_ZERO;
              end else if (cnt >= CNT_MAX - CNT_ONE) begin
                state <= IDLE;
                cnt   <= CNT_ZERO;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
            default: begin
              state <= IDLE;
              cnt   <= CNT_ZERO;
            end
          endcase
        end
      end

      assign press_evt[i] = evt;
    end
  endgenerate

  // Command register: simultaneous presses are suppressed so s and r are never both high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s        <= 1'b0;
      r        <= 1'b0;
      c        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= press_evt[0] & ~press_evt[1];
      r        <= press_evt[1] & ~press_evt[0];
      c        <= press_evt[0] ^ press_evt[1];
      conflict <= press_evt[0] & press_evt[1];
    end
  end

`ifdef SR_DRV_SHADOW_EN
  logic q_shadow;

  // Shadow of the latch contents, following each command one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_shadow <= 1'b0;
    end else if (s) begin
      q_shadow <= 1'b1;
    end else if (r) begin
      q_shadow <= 1'b0;
    end
  end

  assign q_exp = q_shadow;
`else
  assign q_exp = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - directed self-checking bench for sr_latch_driver
module tb_sr_latch_driver;

`ifdef SR_DRV_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk;
  logic reset;
  logic key_set_n;
  logic key_clr_n;
  logic s;
  logic r;
  logic c;
  logic conflict;
  logic q_exp;

  int checks;
  int errors;

  sr_latch_driver #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_set_n (key_set_n),
    .key_clr_n (key_clr_n),
    .s         (s),
    .r         (r),
    .c         (c),
    .conflict  (conflict),
    .q_exp     (q_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles sampling 1ns after each rising edge. s_at/r_at/cf_at give the
  // cycle (1-based, counted from the call) where that pulse is expected, 0 for none.
  // The shadow is expected to hold q_before up to and including the pulse cycle
  // and q_after from the following cycle on.
  task automatic run_window(input string name, input int n, input int s_at,
                            input int r_at, input int cf_at,
                            input bit q_before, input bit q_after);
    int cmd_at;
    bit exp_s, exp_r, exp_cf, exp_q;
    cmd_at = (s_at > r_at) ? s_at : r_at;
    for (int cyc = 1; cyc <= n; cyc++) begin
      @(posedge clk);
      #1;
      exp_s  = (cyc == s_at);
      exp_r  = (cyc == r_at);
      exp_cf = (cyc == cf_at);
      exp_q  = (cmd_at > 0 && cyc > cmd_at) ? q_after : q_before;
      check($sformatf("%s s cyc%0d", name, cyc), {31'd0, s}, {31'd0, exp_s});
      check($sformatf("%s r cyc%0d", name, cyc), {31'd0, r}, {31'd0, exp_r});
      check($sformatf("%s c cyc%0d", name, cyc), {31'd0, c}, {31'd0, exp_s | exp_r});
      check($sformatf("%s conflict cyc%0d", name, cyc), {31'd0, conflict}, {31'd0, exp_cf});
      check($sformatf("%s q_exp cyc%0d", name, cyc), {31'd0, q_exp}, {31'd0, SHADOW & exp_q});
      check($sformatf("%s s&r cyc%0d", name, cyc), {31'd0, s & r}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " s"}, {31'd0, s}, 32'd0);
    check({name, " r"}, {31'd0, r}, 32'd0);
    check({name, " c"}, {31'd0, c}, 32'd0);
    check({name, " conflict"}, {31'd0, conflict}, 32'd0);
    check({name, " q_exp"}, {31'd0, q_exp}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    key_set_n = 1'b1;
    key_clr_n = 1'b1;

    // Reset held for 3 cycles, then 20 quiet cycles.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    run_window("idle", 20, 0, 0, 0, 1'b0, 1'b0);

    // Clean set press held 30 cycles: one s pulse at cycle 7.
    key_set_n = 1'b0;
    run_window("clean", 30, 7, 0, 0, 1'b0, 1'b1);
    key_set_n = 1'b1;
    run_window("clean_rel", 10, 0, 0, 0, 1'b1, 1'b1);

    // Bouncing clear key: 2 low / 1 high five times, then steady low.
    for (int k = 0; k < 5; k++) begin
      key_clr_n = 1'b0;
      run_window("bounce_lo", 2, 0, 0, 0, 1'b1, 1'b1);
      key_clr_n = 1'b1;
      run_window("bounce_hi", 1, 0, 0, 0, 1'b1, 1'b1);
    end
    key_clr_n = 1'b0;
    run_window("bounce", 20, 0, 7, 0, 1'b1, 1'b0);
    key_clr_n = 1'b1;
    run_window("bounce_rel", 10, 0, 0, 0, 1'b0, 1'b0);

    // Both keys fall together: conflict only, no command, shadow unchanged.
    key_set_n = 1'b0;
    key_clr_n = 1'b0;
    run_window("simul", 20, 0, 0, 7, 1'b0, 1'b0);
    key_set_n = 1'b1;
    key_clr_n = 1'b1;
    run_window("simul_rel", 10, 0, 0, 0, 1'b0, 1'b0);

    // Clear pressed while set is still held: normal r pulse.
    key_set_n = 1'b0;
    run_window("hold_set", 10, 7, 0, 0, 1'b0, 1'b1);
    key_clr_n = 1'b0;
    run_window("clr_while_held", 10, 0, 7, 0, 1'b1, 1'b0);
    key_set_n = 1'b1;
    key_clr_n = 1'b1;
    run_window("hold_rel", 10, 0, 0, 0, 1'b0, 1'b0);

    // Set shadow high, then reset mid-count on a fresh press.
    key_set_n = 1'b0;
    run_window("pre_mid", 10, 7, 0, 0, 1'b0, 1'b1);
    key_set_n = 1'b1;
    run_window("pre_mid_rel", 10, 0, 0, 0, 1'b1, 1'b1);
    key_set_n = 1'b0;
    run_window("mid_count", 3, 0, 0, 0, 1'b1, 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_window("after_reset", 12, 7, 0, 0, 1'b0, 1'b1);
    key_set_n = 1'b1;
    run_window("final_rel", 10, 0, 0, 0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
